alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream stage of the 4-bit ALU. Buffers {op, b, a} commands in a small FIFO
//  and issues them one at a time on the ALU operand/select lines.
//  Waits the ALU's registered latency, then captures the 8-bit result and
//  presents it on a valid/ready output port. Divide-by-zero is trapped locally;
//  that command is never issued to the ALU.
// PARAMETERS
//  DEPTH    4   command FIFO entries; power of two, 2..8
//  ALU_LAT  1   clock cycles from driving alu_a/alu_b/alu_sel to a valid alu_res
// PORTS
//  clk        in   1  single clock; all logic on posedge
//  rst        in   1  synchronous reset, active-high
//  in_valid   in   1  command present on in_a/in_b/in_op
//  in_ready   out  1  FIFO can accept (= !full)
//  in_a       in   4  operand A
//  in_b       in   4  operand B
//  in_op      in   2  00 add, 01 sub, 10 mul, 11 div
//  alu_a      out  4  operand A to ALU (registered)
//  alu_b      out  4  operand B to ALU (registered)
//  alu_sel    out  2  op select to ALU (registered)
//  alu_res    in   8  result from ALU
//  res_valid  out  1  res_* holds a result
//  res_ready  in   1  downstream accepts result
//  res_data   out  8  captured result
//  res_op     out  2  op that produced res_data
//  res_err    out  1  1 = divide-by-zero trap; res_data = 8'hFF
//  level      out  4  FIFO occupancy, 0..DEPTH
//  err_cnt    out  8  trapped-error count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - FIFO emptied, level=0; FSM to IDLE.
//   - res_valid=0; res_data, res_op, res_err, alu_a, alu_b, alu_sel all 0; err_cnt=0.
//   - In-flight ALU op is abandoned (reset mid-operation included).
//  FIFO:
//   - Push when in_valid && in_ready. Pop only by the FSM in IDLE.
//   - Push and pop in the same cycle: level unchanged.
//   - Full: in_ready=0; a same-cycle pop does NOT re-open in_ready.
//   - Pointers wrap modulo DEPTH.
//  FSM states:
//   - IDLE: if !empty, pop head.
//     - Head is op=11 and b=0: load res_data=8'hFF, res_err=1, res_op=11, go HOLD. No ALU issue.
//     - Otherwise: register head into alu_a/alu_b/alu_sel, clear wait counter, go WAIT.
//   - WAIT: count ALU_LAT cycles after the issue edge. At the ALU_LAT-th edge, capture
//     alu_res into res_data, res_op=alu_sel, res_err=0, go HOLD.
//   - HOLD: res_valid=1. res_* stable until res_valid && res_ready.
//     On handshake: res_valid=0 next cycle, go IDLE.
//  Latency:
//   - Command at FIFO head in IDLE to res_valid high is 2+ALU_LAT cycles
//     (pop/issue, ALU_LAT wait, capture).
//   - Trap path is 1 cycle.
//  Throughput and hold:
//   - One command in flight. The next pop happens at the earliest in the cycle after the handshake.
//   - alu_* hold their last issued value while idle; they are not cleared.
//  Result width: res_data = alu_res[7:0] verbatim, no reinterpretation.
//   - add/sub use bits [4:0]; sub wraps modulo 32.
//   - mul uses [7:0]; div uses [3:0].
// CONFIGURATION
//  ALU_SEQ_ERR_COUNT_EN defined:
//   - err_cnt increments on each trap entry into HOLD.
//   - Saturates at 8'hFF; cleared only by rst.
//  ALU_SEQ_ERR_COUNT_EN undefined:
//   - err_cnt tied to 8'h00; no counter logic.
//   - Trap behaviour (res_err, 8'hFF) is unchanged.
// TESTING
//  1. Push {op=00,a=9,b=7} with res_ready=1, ALU model ALU_LAT=1
//     -> alu_sel=00, a=9, b=7 issued; res_data=8'h10, res_err=0, res_valid 3 cycles after pop.
//  2. Push {11,a=5,b=0}
//     -> no change on alu_*; res_data=8'hFF, res_err=1; err_cnt=1 with macro, 0 without.
//  3. res_ready=0, push 5 commands (DEPTH=4, one popped)
//     -> in_ready=0 once level=4; res_* stable for 10 cycles;
//     after res_ready=1, results drain in push order.
//  4. Push {01,a=3,b=5} -> res_data=8'h1E (5-bit wrap of -2).
//     Push {10,a=15,b=15} -> res_data=8'hE1.
//  5. Assert rst during WAIT with level=2
//     -> next cycle: level=0, res_valid=0, all outputs 0; no stale result appears.
//  6. Push every cycle while draining with res_ready=1
//     -> level never exceeds DEPTH; no command lost or duplicated; order preserved.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers {op,b,a} commands, issues them to a registered ALU, returns results on a valid/ready port
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        command handshake; in_a, in_b (4b), in_op (2b: add/sub/mul/div)
//   alu_a, alu_b, alu_sel    registered operands/select to the ALU; alu_res (8b) comes back ALU_LAT cycles later
//   res_valid/res_ready      result handshake; res_data (8b), res_op (2b), res_err (divide-by-zero trap)
//   level                    FIFO occupancy 0..DEPTH
//   err_cnt                  saturating trap count when ALU_SEQ_ERR_COUNT_EN is defined, else 0
module alu_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic [1:0] in_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_sel,
   input  logic [7:0] alu_res,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [1:0] res_op,
   output logic       res_err,
   output logic [3:0] level,
   output logic [7:0] err_cnt
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
   state_t state;
   logic [9:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [7:0] wcnt;
   logic push, pop, head_trap;
   logic [9:0] head;
   // in_ready follows the registered level, so a pop while full cannot reopen it the same cycle
   assign in_ready = level != 4'(DEPTH);
   assign push = in_valid && in_ready;
   assign pop = state == IDLE && level != 4'd0;
   assign head = mem[rp];
   assign head_trap = head[9:8] == 2'b11 && head[7:4] == 4'd0;
   always_ff @(posedge clk)
      if (push) mem[wp] <= {in_op, in_b, in_a};
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wp        <= '0;
         rp        <= '0;
         level     <= '0;
         wcnt      <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
         res_err   <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         level <= level + 4'(push) - 4'(pop);
         case (state)
            IDLE:
               if (pop) begin
                  if (head_trap) begin
                     res_data  <= 8'hFF;
                     res_op    <= 2'b11;
                     res_err   <= 1'b1;
                     res_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     alu_a   <= head[3:0];
                     alu_b   <= head[7:4];
                     alu_sel <= head[9:8];
                     wcnt    <= '0;
                     state   <= WAIT;
                  end
               end
            // alu_res reflects the issued operands ALU_LAT edges after issue; it is sampled on the following edge
            WAIT:
               if (wcnt == 8'(ALU_LAT)) begin
                  res_data  <= alu_res;
                  res_op    <= alu_sel;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end else wcnt <= wcnt + 8'd1;
            HOLD:
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef ALU_SEQ_ERR_COUNT_EN
   always_ff @(posedge clk)
      err_cnt <= rst ? 8'h00 : (pop && head_trap && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
`else
   assign err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench for alu_cmd_sequencer with a registered 1-cycle ALU stub
module tb_alu_cmd_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_ready;
   logic [3:0] in_a = '0, in_b = '0;
   logic [1:0] in_op = '0;
   logic [3:0] alu_a, alu_b;
   logic [1:0] alu_sel;
   logic [7:0] alu_res = '0;
   logic res_valid, res_ready = 1'b1, res_err;
   logic [7:0] res_data, err_cnt;
   logic [1:0] res_op;
   logic [3:0] level;
   int checks = 0, errors = 0;
   int max_level = 0;
   logic [10:0] q[$];
   logic [7:0] exp_err_cnt;

   alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_op(res_op), .res_err(res_err), .level(level), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      logic [4:0] r5;
      case (s)
         2'd0: begin r5 = {1'b0, a} + {1'b0, b}; alu_f = {3'b0, r5}; end
         2'd1: begin r5 = {1'b0, a} - {1'b0, b}; alu_f = {3'b0, r5}; end
         2'd2: alu_f = {4'b0, a} * {4'b0, b};
         default: alu_f = (b == 4'd0) ? 8'hEE : {4'b0, a / b};
      endcase
   endfunction

   always @(posedge clk) alu_res <= alu_f(alu_a, alu_b, alu_sel);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // monitor: compare each accepted result with the oldest expected entry
   always @(negedge clk) begin
      if (int'(level) > max_level) max_level = int'(level);
      if (!rst && res_valid && res_ready) begin
         if (q.size() == 0) chk("unexpected_result", {21'b0, res_err, res_op, res_data}, 32'hDEAD);
         else chk("result", {21'b0, res_err, res_op, res_data}, {21'b0, q.pop_front()});
      end
   end

   // all stimulus runs at #1 after a posedge
   task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input logic err);
      int t = 0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
      if (t >= 300) chk("push_timeout", 0, 1);
      @(posedge clk);
      q.push_back({err, op, exp});
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() != 0 || res_valid) && t < 300) begin @(posedge clk); #1; t++; end
      chk("drain_done", t < 300, 1);
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [1:0] v_op [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2};
   logic [3:0] v_a  [10] = '{4'd15, 4'd3, 4'd0, 4'd9, 4'd7, 4'd0, 4'd15, 4'd9, 4'd8, 4'd12};
   logic [3:0] v_b  [10] = '{4'd15, 4'd4, 4'd1, 4'd2, 4'd6, 4'd9, 4'd4, 4'd0, 4'd2, 4'd11};
   logic [7:0] v_e  [10] = '{8'h1E, 8'h07, 8'h1F, 8'h07, 8'h2A, 8'h00, 8'h03, 8'hFF, 8'h04, 8'h84};
   logic       v_r  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [10:0] snap;
      logic stable;
      logic seen;
`ifdef ALU_SEQ_ERR_COUNT_EN
      exp_err_cnt = 8'd1;
`else
      exp_err_cnt = 8'd0;
`endif
      step(2);
      rst = 1'b0;
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res", {res_err, res_op, res_data}, 0);
      chk("rst_alu", {alu_sel, alu_b, alu_a}, 0);
      chk("rst_err_cnt", err_cnt, 0);
      // add 9+7 with latency check
      push(2'b00, 4'd9, 4'd7, 8'h10, 1'b0);
      step(1);
      chk("t1_issue", {alu_sel, alu_b, alu_a}, {2'b00, 4'd7, 4'd9});
      chk("t1_valid_early", res_valid, 0);
      step(1);
      chk("t1_valid_wait", res_valid, 0);
      step(1);
      chk("t1_valid", res_valid, 1);
      chk("t1_data", res_data, 8'h10);
      drain();
      // divide-by-zero trap
      push(2'b11, 4'd5, 4'd0, 8'hFF, 1'b1);
      step(1);
      chk("t2_valid", res_valid, 1);
      chk("t2_trap", {res_err, res_op, res_data}, {1'b1, 2'b11, 8'hFF});
      chk("t2_alu_held", {alu_sel, alu_b, alu_a}, {2'b00, 4'd7, 4'd9});
      chk("t2_err_cnt", err_cnt, exp_err_cnt);
      drain();
      // backpressure: fill FIFO behind a held result
      res_ready = 1'b0;
      push(2'b00, 4'd1, 4'd2, 8'h03, 1'b0);
      push(2'b01, 4'd8, 4'd3, 8'h05, 1'b0);
      push(2'b10, 4'd3, 4'd3, 8'h09, 1'b0);
      push(2'b11, 4'd9, 4'd3, 8'h03, 1'b0);
      push(2'b00, 4'd15, 4'd1, 8'h10, 1'b0);
      chk("t3_level_full", level, 4);
      chk("t3_in_ready_full", in_ready, 0);
      chk("t3_held_valid", res_valid, 1);
      snap = {res_err, res_op, res_data};
      stable = 1'b1;
      repeat (10) begin
         step(1);
         stable &= res_valid && {res_err, res_op, res_data} == snap && level == 4'd4;
      end
      chk("t3_stable", stable, 1);
      res_ready = 1'b1;
      step(1);
      chk("t3_full_after_hs", {in_ready, level}, {1'b0, 4'd4});
      step(1);
      chk("t3_after_pop", {in_ready, level}, {1'b1, 4'd3});
      drain();
      // sub wrap and mul
      push(2'b01, 4'd3, 4'd5, 8'h1E, 1'b0);
      push(2'b10, 4'd15, 4'd15, 8'hE1, 1'b0);
      drain();
      // reset in WAIT with two queued
      push(2'b00, 4'd2, 4'd3, 8'h05, 1'b0);
      push(2'b00, 4'd4, 4'd4, 8'h08, 1'b0);
      push(2'b00, 4'd6, 4'd1, 8'h07, 1'b0);
      chk("t5_level", level, 2);
      chk("t5_issued", alu_a, 4'd2);
      rst = 1'b1;
      step(1);
      q.delete();
      chk("t5_level_rst", level, 0);
      chk("t5_valid_rst", res_valid, 0);
      chk("t5_outs_rst", {res_err, res_op, res_data, alu_sel, alu_b, alu_a, err_cnt}, 0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin step(1); seen |= res_valid; end
      chk("t5_no_stale", seen, 0);
      // continuous stream
      for (int i = 0; i < 10; i++) push(v_op[i], v_a[i], v_b[i], v_e[i], v_r[i]);
      drain();
      chk("t6_max_level", max_level <= 4, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
